// File: rtl/v_hier_arb.sv
// v_hier_arb: round-robin arbiter/sequencer sharing one 3-lane v_hier_sub datapath among NREQ requesters.
// Optional locked bursts are enabled by defining V_HIER_ARB_LOCK_EN.
module v_hier_arb #(
  parameter int NREQ     = 4,
  parameter int SETTLE   = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_a,
`ifdef V_HIER_ARB_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  output logic [2:0]        rsp_q,
  output logic              busy,
  output logic [2:0]        avec,
  input  logic [2:0]        qvec
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      avec_q, avec_d, res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d, win_q, win_d, pick, idx;
  logic            found, stay;
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
`ifdef V_HIER_ARB_LOCK_EN
  localparam int BW = $clog2(LOCK_MAX + 1);
  logic [BW-1:0] burst_q;
  assign stay = lock[win_q] && req[win_q] && (burst_q < BW'(LOCK_MAX - 1));
  always_ff @(posedge clk) begin
    if (reset) burst_q <= '0;
    else if (state_q == RESP) burst_q <= stay ? burst_q + BW'(1) : '0;
  end
`else
  assign stay = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    avec_d = avec_q;
    res_d = res_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    win_d = win_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = DRIVE;
        gnt_d = '0;
        gnt_d[pick] = 1'b1;
        avec_d = req_a[3*pick +: 3];
        cnt_d = CW'(SETTLE - 1);
        win_d = pick;
      end
      DRIVE: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else begin
          res_d = qvec;
          state_d = RESP;
        end
      RESP: if (stay) begin
        // locked burst: keep the grant and pointer, take a fresh operand
        state_d = DRIVE;
        avec_d = req_a[3*win_q +: 3];
        cnt_d = CW'(SETTLE - 1);
      end else begin
        state_d = IDLE;
        gnt_d = '0;
        avec_d = '0;
        ptr_d = win_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      avec_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      ptr_q <= PW'(NREQ - 1);
      win_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      avec_q <= avec_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
    end
  end
  assign gnt = gnt_q;
  assign avec = avec_q;
  assign rsp_q = res_q;
  assign rsp_valid = (state_q == RESP);
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_v_hier_arb.sv
// tb_v_hier_arb: directed checks of v_hier_arb with a v_hier_sub stand-in qvec = avec ^ xm.
module tb_v_hier_arb;
  localparam logic [11:0] OPS = {3'd4, 3'd3, 3'd2, 3'd1};
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [11:0] req_a = OPS;
  logic [3:0]  gnt;
  logic        rsp_valid, busy;
  logic [2:0]  rsp_q, avec, qvec;
  logic [2:0]  xm = 3'b000;
  int          n_cmp = 0;
  int          n_err = 0;
`ifdef V_HIER_ARB_LOCK_EN
  logic [3:0]  lock = '0;
`endif
  assign qvec = avec ^ xm;
  always #5 clk = ~clk;
  v_hier_arb #(.NREQ(4), .SETTLE(2), .LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a),
`ifdef V_HIER_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_q(rsp_q), .busy(busy),
    .avec(avec), .qvec(qvec)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one full transaction starting from IDLE; drop clears req bits and scrambles operands after grant
  task automatic txn(input logic [3:0] g, input logic [2:0] a, input logic [2:0] r, input logic [3:0] drop);
    tick();
    chk("gnt", 32'(gnt), 32'(g));
    chk("avec", 32'(avec), 32'(a));
    chk("busy", 32'(busy), 1);
    chk("vld_drive0", 32'(rsp_valid), 0);
    req = req & ~drop;
    if (drop != '0) req_a = ~req_a;
    tick();
    chk("gnt_hold", 32'(gnt), 32'(g));
    chk("vld_drive1", 32'(rsp_valid), 0);
    tick();
    chk("vld", 32'(rsp_valid), 1);
    chk("rsp", 32'(rsp_q), 32'(r));
    chk("gnt_resp", 32'(gnt), 32'(g));
    tick();
    chk("gnt_idle", 32'(gnt), 0);
    chk("vld_off", 32'(rsp_valid), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("avec_idle", 32'(avec), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_vld", 32'(rsp_valid), 0);
    chk("rst_rsp", 32'(rsp_q), 0);
    chk("rst_avec", 32'(avec), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    req_a = 12'b000_000_000_101;
    req = 4'b0001;
    txn(4'b0001, 3'b101, 3'b101, 4'b0000);
    req = '0;
    tick();
    chk("idle_quiet", 32'(busy), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_a = OPS;
    xm = 3'b110;
    req = 4'b1111;
    txn(4'b0001, 3'd1, 3'd7, 4'b0000);
    txn(4'b0010, 3'd2, 3'd4, 4'b0000);
    txn(4'b0100, 3'd3, 3'd5, 4'b0000);
    txn(4'b1000, 3'd4, 3'd2, 4'b0000);
    txn(4'b0001, 3'd1, 3'd7, 4'b0000);
    req = 4'b0010;
    txn(4'b0010, 3'd2, 3'd4, 4'b0000);
    req = 4'b1010;
    txn(4'b1000, 3'd4, 3'd2, 4'b0000);
    txn(4'b0010, 3'd2, 3'd4, 4'b0000);
    req = 4'b0011;
    txn(4'b0001, 3'd1, 3'd7, 4'b0001);
    req_a = OPS;
    txn(4'b0010, 3'd2, 3'd4, 4'b0000);
    req = 4'b0100;
    tick();
    chk("pre_rst_gnt", 32'(gnt), 32'(4'b0100));
    reset = 1'b1;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_avec", 32'(avec), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_vld", 32'(rsp_valid), 0);
    reset = 1'b0;
    req = 4'b0101;
    txn(4'b0001, 3'd1, 3'd7, 4'b0000);
    txn(4'b0100, 3'd3, 3'd5, 4'b0000);
    req = '0;
`ifdef V_HIER_ARB_LOCK_EN
    req = 4'b0010;
    txn(4'b0010, 3'd2, 3'd4, 4'b0000);
    req = 4'b0101;
    lock = 4'b0100;
    tick();
    chk("lk_gnt", 32'(gnt), 32'(4'b0100));
    for (int b = 0; b < 4; b++) begin
      chk("lk_avec", 32'(avec), 32'(3 + b));
      tick();
      chk("lk_vld0", 32'(rsp_valid), 0);
      tick();
      chk("lk_vld", 32'(rsp_valid), 1);
      chk("lk_rsp", 32'(rsp_q), 32'(3'(3 + b) ^ 3'b110));
      req_a[8:6] = 3'(4 + b);
      tick();
      chk("lk_gnt_next", 32'(gnt), (b < 3) ? 32'(4'b0100) : 0);
      chk("lk_busy_next", 32'(busy), (b < 3) ? 1 : 0);
    end
    req_a = OPS;
    txn(4'b0001, 3'd1, 3'd7, 4'b0000);
    req = '0;
    lock = '0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/v_hier_arb.md
Name: v_hier_arb

Overview:
- Round-robin arbiter and sequencer that shares one 3-lane v_hier_sub datapath among NREQ requesters.
- Per transaction: grants one requester, drives its 3-bit operand onto avec, waits SETTLE cycles, samples qvec, returns the result with a one-cycle valid pulse.
- Sits directly above the v_hier_sub instance; its avec/qvec ports connect straight to that instance.

Parameters:
NREQ, 4, number of requesters (>=2)
SETTLE, 2, cycles avec is held before qvec is sampled (>=1)
LOCK_MAX, 4, max back-to-back transactions per locked grant (used only with V_HIER_ARB_LOCK_EN)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
req  input  NREQ  per-requester request, held until rsp_valid
req_a  input  3*NREQ  operands, requester i on bits [3i+2:3i]
gnt  output  NREQ  one-hot grant, registered
rsp_valid  output  1  one-cycle result strobe to the granted requester
rsp_q  output  3  sampled result, valid with rsp_valid
busy  output  1  high whenever state != IDLE
avec  output  3  operand driven to v_hier_sub
qvec  input  3  result from v_hier_sub

Behaviour:
- Reset (synchronous, wins over everything): state=IDLE; gnt=0, rsp_valid=0, rsp_q=0, avec=0, busy=0; rr pointer=NREQ-1, so requester 0 wins first.
- States: IDLE, DRIVE, RESP.
- IDLE:
  - If req==0, stay in IDLE with avec=0.
  - Otherwise pick the first set req bit searching from (ptr+1) mod NREQ upward with wrap.
  - Next edge: gnt=onehot(winner), latch avec=req_a[winner], cnt=SETTLE-1, go to DRIVE.
- DRIVE:
  - avec and gnt held constant.
  - If cnt!=0, decrement cnt.
  - If cnt==0, next edge: rsp_q=qvec, rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid high exactly this cycle; gnt still asserted.
  - Next edge: rsp_valid=0, gnt=0, avec=0, ptr=winner, go to IDLE.
- Latency: req seen in IDLE at edge t -> gnt/avec at t+1 -> qvec sampled at edge t+SETTLE -> rsp_valid high during cycle t+SETTLE+1. Transaction occupies SETTLE+2 cycles; IDLE always costs one arbitration cycle between transactions.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,NREQ-1,0. No requester waits more than NREQ-1 transactions.
- Request dropped while DRIVE or RESP: the transaction still completes and rsp_valid still pulses. No abort path.
- req_a changes after grant: ignored; the operand is latched in IDLE.
- Simultaneous requests: the pointer rule decides; the lowest index wins only when ptr=NREQ-1.
- Reset mid-transaction: outputs return to reset values on the next edge and no rsp_valid is issued.
- Pointer width is $clog2(NREQ); the increment wraps modulo NREQ, including for non-power-of-2 NREQ.

Optional Feature:
- Macro V_HIER_ARB_LOCK_EN.
- When defined:
  - Extra input lock[NREQ-1:0].
  - In RESP, if lock[winner] && req[winner] && burst count < LOCK_MAX-1: go directly to DRIVE with the same gnt, latch the new req_a[winner], reload cnt, increment burst count, and leave ptr unchanged.
  - Otherwise proceed to IDLE as normal and clear burst count.
  - Burst count resets to 0.
- When undefined: no lock port, no burst counter; RESP always goes to IDLE.

Test Plan:
1. Reset, then req=4'b0001, req_a[2:0]=3'b101, qvec model = avec -> gnt=0001 at t+1, avec=101, rsp_valid at t+3 with rsp_q=101, gnt=0 and busy=0 at t+4.
2. All four requesters request continuously with operands 1,2,3,4 -> grant order 0,1,2,3,0; one transaction per 4 cycles; each rsp_q matches its operand.
3. req=4'b1010 after requester 1 was served -> requester 3 granted before 1.
4. Drop req[0] in the first DRIVE cycle -> rsp_valid still pulses; next grant goes to the next requester.
5. Assert reset during DRIVE -> next cycle gnt=0, avec=0, busy=0, and no rsp_valid; first post-reset grant goes to requester 0.
6. (LOCK_EN) lock[2]=1, req=4'b0101 continuous, LOCK_MAX=4 -> four back-to-back grants to 2 with no IDLE gap, then IDLE, then requester 0 granted.
